// File: rtl/baud_pkg.sv
// Shared constants and the default-divisor helper for the baud rate generator.
package baud_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned DIV_W_DEF      = 16;
   localparam int unsigned FRAC_W         = 4;

   // Round-to-nearest clk cycles per oversample tick; 0 when the rate product is 0.
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned os);
      longint unsigned w_den;
      w_den = 64'(baud) * 64'(os);
      if (w_den == 64'd0) return 32'd0;
      return 32'((64'(clk_hz) + (w_den >> 1)) / w_den);
   endfunction

endpackage

// File: rtl/baud_prescaler.sv
// Divisor registers, staged reload, optional fractional accumulator and os_tick.
// Fractional division is built only when BAUD_GEN_FRAC_EN is defined.
module baud_prescaler
   import baud_pkg::*;
#(
   parameter int unsigned DIV_W   = DIV_W_DEF,
   parameter int unsigned DIV_RST = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_en,
   input  logic              i_sync,
   input  logic [DIV_W-1:0]  i_div_value,
   input  logic [FRAC_W-1:0] i_div_frac,
   input  logic              i_div_load,
   output logic              o_os_tick,
   output logic              o_wrap_c,
   output logic [DIV_W-1:0]  o_div_active
);

   logic [DIV_W-1:0] r_div_active;
   logic [DIV_W-1:0] r_stage_div;
   logic             r_stage_vld;
   logic [DIV_W-1:0] r_pcnt;
   logic             r_os_tick;

   logic [DIV_W-1:0] w_d_eff;
   logic [DIV_W-1:0] w_term;
   logic             w_carry;
   logic             w_wrap;
   logic             w_load_now;
   logic             w_stage_set;
   logic             w_apply;

   // A load takes effect at once when idle or restarting, otherwise waits for the wrap.
   assign w_load_now  = i_div_load & (i_sync | ~i_en);
   assign w_stage_set = i_div_load & i_en & ~i_sync;
   assign w_apply     = w_wrap & r_stage_vld;

   assign w_d_eff = (r_div_active == '0) ? DIV_W'(1) : r_div_active;
   assign w_term  = w_d_eff - DIV_W'(1) + DIV_W'(w_carry);
   // >= keeps an immediate shrink of the divisor from running the counter past its end.
   assign w_wrap  = i_en & ~i_sync & (r_pcnt >= w_term);

`ifdef BAUD_GEN_FRAC_EN
   logic [FRAC_W-1:0] r_frac_active;
   logic [FRAC_W-1:0] r_stage_frac;
   logic [FRAC_W-1:0] r_acc;
   logic [FRAC_W:0]   w_acc_sum;

   // The carry of this period's accumulation stretches this period by one cycle.
   assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac_active};
   assign w_carry   = w_acc_sum[FRAC_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frac_active <= '0;
         r_stage_frac  <= '0;
         r_acc         <= '0;
      end else begin
         if (w_load_now)
            r_frac_active <= i_div_frac;
         else if (w_apply)
            r_frac_active <= r_stage_frac;
         if (w_stage_set)
            r_stage_frac <= i_div_frac;
         if (i_sync)
            r_acc <= '0;
         else if (w_wrap)
            r_acc <= w_acc_sum[FRAC_W-1:0];
      end
   end
`else
   logic w_unused_frac;

   assign w_carry       = 1'b0;
   assign w_unused_frac = ^i_div_frac;
`endif

   // Active and staged divisor.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_active <= DIV_W'(DIV_RST);
         r_stage_div  <= '0;
         r_stage_vld  <= 1'b0;
      end else begin
         if (w_load_now)
            r_div_active <= i_div_value;
         else if (w_apply)
            r_div_active <= r_stage_div;

         if (w_stage_set) begin
            r_stage_div <= i_div_value;
            r_stage_vld <= 1'b1;
         end else if (w_load_now || w_apply) begin
            r_stage_vld <= 1'b0;
         end
      end
   end

   // Prescaler count and registered os_tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt    <= '0;
         r_os_tick <= 1'b0;
      end else if (i_sync) begin
         r_pcnt    <= '0;
         r_os_tick <= 1'b0;
      end else if (i_en) begin
         r_pcnt    <= w_wrap ? '0 : r_pcnt + DIV_W'(1);
         r_os_tick <= w_wrap;
      end else begin
         r_os_tick <= 1'b0;
      end
   end

   assign o_os_tick    = r_os_tick;
   assign o_wrap_c     = w_wrap;
   assign o_div_active = r_div_active;

endmodule

// File: rtl/baud_gen.sv
// UART baud rate generator: oversample tick, bit tick and 50% baud clock.
// Define BAUD_GEN_FRAC_EN to enable fractional (sixteenths) division.
module baud_gen
   import baud_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned BAUD_DEFAULT = 9600,
   parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF,
   parameter int unsigned DIV_W        = DIV_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              sync,
   input  logic [DIV_W-1:0]  div_value,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   output logic              os_tick,
   output logic              baud_tick,
   output logic              baud_clk,
   output logic [DIV_W-1:0]  div_active
);

   localparam int unsigned OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int unsigned DIV_RST = calc_div(CLK_FREQ_HZ, BAUD_DEFAULT, OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

   logic            w_wrap;
   logic [OS_W-1:0] w_os_nxt;
   logic [OS_W-1:0] r_os_cnt;
   logic            r_baud_tick;
   logic            r_baud_clk;

   baud_prescaler #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
   ) u_prescaler (
      .clk          (clk),
      .rst_n        (reset),
      .i_en         (en),
      .i_sync       (sync),
      .i_div_value  (div_value),
      .i_div_frac   (div_frac),
      .i_div_load   (div_load),
      .o_os_tick    (os_tick),
      .o_wrap_c     (w_wrap),
      .o_div_active (div_active)
   );

   assign w_os_nxt = (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);

   // Oversample counter advances on the same edge that raises os_tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_os_cnt    <= '0;
         r_baud_tick <= 1'b0;
         r_baud_clk  <= 1'b1;
      end else if (sync) begin
         r_os_cnt    <= '0;
         r_baud_tick <= 1'b0;
         r_baud_clk  <= 1'b1;
      end else if (w_wrap) begin
         r_os_cnt    <= w_os_nxt;
         r_baud_tick <= (r_os_cnt == OS_LAST);
         r_baud_clk  <= (w_os_nxt < OS_HALF);
      end else begin
         r_baud_tick <= 1'b0;
      end
   end

   assign baud_tick = r_baud_tick;
   assign baud_clk  = r_baud_clk;

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen at 1.536 MHz / 9600 baud / 16x oversample (default divisor 10).
module tb_baud_gen;

   localparam int unsigned DIV_W = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             en = 1'b0;
   logic             sync = 1'b0;
   logic [DIV_W-1:0] div_value = '0;
   logic [3:0]       div_frac = '0;
   logic             div_load = 1'b0;
   logic             os_tick;
   logic             baud_tick;
   logic             baud_clk;
   logic [DIV_W-1:0] div_active;

   int checks = 0;
   int errors = 0;

   baud_gen #(
      .CLK_FREQ_HZ  (1_536_000),
      .BAUD_DEFAULT (9600),
      .OVERSAMPLE   (16),
      .DIV_W        (DIV_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .sync       (sync),
      .div_value  (div_value),
      .div_frac   (div_frac),
      .div_load   (div_load),
      .os_tick    (os_tick),
      .baud_tick  (baud_tick),
      .baud_clk   (baud_clk),
      .div_active (div_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DIV_W-1:0] dv;
      int               os_p;
      int               baud_p;
      int               half;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sel(input int which);
      case (which)
         0:       return os_tick;
         1:       return baud_tick;
         default: return baud_clk;
      endcase
   endfunction

   // Steps until the selected output equals val; -1 when the budget runs out.
   task automatic wait_sig(input int which, input logic val, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (sel(which) !== val && n < 2000);
      if (sel(which) !== val) n = -1;
   endtask

   task automatic load_idle(input logic [DIV_W-1:0] dv, input logic [3:0] fr);
      en        = 1'b0;
      div_value = dv;
      div_frac  = fr;
      div_load  = 1'b1;
      step();
      div_load  = 1'b0;
   endtask

   task automatic do_sync();
      en   = 1'b1;
      sync = 1'b1;
      step();
      sync = 1'b0;
   endtask

   initial begin
      int n, tot, ticks, p0, p1;
      logic held;

      vecs[0] = '{16'd10, 10, 160, 80};
      vecs[1] = '{16'd4,   4,  64, 32};
      vecs[2] = '{16'd0,   1,  16,  8};
      vecs[3] = '{16'd1,   1,  16,  8};
      vecs[4] = '{16'd3,   3,  48, 24};

      // Reset values and default-rate timing.
      #2 reset = 1'b0;
      #10;
      check("rst os_tick", int'(os_tick), 0);
      check("rst baud_tick", int'(baud_tick), 0);
      check("rst baud_clk", int'(baud_clk), 1);
      check("rst div_active", int'(div_active), 10);
      step();
      reset = 1'b1;
      step();
      en = 1'b1;
      wait_sig(0, 1'b1, n); check("dflt first os", n, 10); tot = n;
      wait_sig(0, 1'b1, n); check("dflt os period", n, 10); tot += n;
      wait_sig(1, 1'b1, n); tot += n; check("dflt baud period", tot, 160);
      wait_sig(2, 1'b0, n); check("dflt baud_clk high", n, 80);
      wait_sig(2, 1'b1, n); check("dflt baud_clk low", n, 80);

      // Divisor table: immediate load while idle, then full period measurement.
      for (int i = 0; i < 5; i++) begin
         load_idle(vecs[i].dv, 4'd0);
         check($sformatf("v%0d div_active", i), int'(div_active), int'(vecs[i].dv));
         do_sync();
         check($sformatf("v%0d sync os_tick", i), int'(os_tick), 0);
         check($sformatf("v%0d sync baud_clk", i), int'(baud_clk), 1);
         wait_sig(0, 1'b1, n); check($sformatf("v%0d first os", i), n, vecs[i].os_p); tot = n;
         wait_sig(0, 1'b1, n); check($sformatf("v%0d os period", i), n, vecs[i].os_p); tot += n;
         wait_sig(1, 1'b1, n); tot += n; check($sformatf("v%0d baud period", i), tot, vecs[i].baud_p);
         wait_sig(2, 1'b0, n); check($sformatf("v%0d clk high", i), n, vecs[i].half);
         wait_sig(2, 1'b1, n); check($sformatf("v%0d clk low", i), n, vecs[i].half);
      end

      // Mid-period load is staged until the current 10-cycle period ends.
      load_idle(16'd10, 4'd0);
      do_sync();
      repeat (3) step();
      div_value = 16'd4; div_load = 1'b1; step(); div_load = 1'b0;
      check("stage not active", int'(div_active), 10);
      wait_sig(0, 1'b1, n); check("stage rest of period", n, 6);
      check("stage active at wrap", int'(div_active), 4);
      wait_sig(0, 1'b1, n); check("stage new period a", n, 4);
      wait_sig(0, 1'b1, n); check("stage new period b", n, 4);

      // Second staged load overwrites the first.
      do_sync();
      div_value = 16'd7; div_load = 1'b1; step();
      div_value = 16'd5; step(); div_load = 1'b0;
      check("overwrite not active", int'(div_active), 4);
      wait_sig(0, 1'b1, n); check("overwrite rest", n, 2);
      check("overwrite active", int'(div_active), 5);
      wait_sig(0, 1'b1, n); check("overwrite period", n, 5);

      // Sync together with load uses the new divisor at once.
      div_value = 16'd4; div_load = 1'b1; sync = 1'b1; step();
      div_load = 1'b0; sync = 1'b0;
      check("sync+load div_active", int'(div_active), 4);
      check("sync+load os_tick", int'(os_tick), 0);
      wait_sig(0, 1'b1, n); check("sync+load first os", n, 4);

      // Sync with os_cnt=7 mid-period, D=10.
      load_idle(16'd10, 4'd0);
      do_sync();
      for (int k = 0; k < 7; k++) wait_sig(0, 1'b1, n);
      repeat (3) step();
      do_sync();
      check("sync7 os_tick", int'(os_tick), 0);
      check("sync7 baud_tick", int'(baud_tick), 0);
      check("sync7 baud_clk", int'(baud_clk), 1);
      wait_sig(0, 1'b1, n); check("sync7 first os", n, 10); tot = n;
      wait_sig(1, 1'b1, n); tot += n; check("sync7 baud", tot, 160);

      // Sync while baud_clk is low forces it high.
      do_sync();
      for (int k = 0; k < 9; k++) wait_sig(0, 1'b1, n);
      check("os9 baud_clk low", int'(baud_clk), 0);
      do_sync();
      check("sync9 baud_clk", int'(baud_clk), 1);

      // en=0 holds counters and baud_clk, suppresses ticks.
      for (int k = 0; k < 9; k++) wait_sig(0, 1'b1, n);
      repeat (3) step();
      en = 1'b0;
      held = baud_clk;
      ticks = 0;
      repeat (20) begin
         step();
         if (os_tick === 1'b1 || baud_tick === 1'b1) ticks++;
         if (baud_clk !== held) ticks++;
      end
      check("hold no activity", ticks, 0);
      check("hold baud_clk low", int'(baud_clk), 0);
      en = 1'b1;
      wait_sig(0, 1'b1, n); check("hold resume", n, 7);

      // Asynchronous reset mid-period with D=4 active.
      load_idle(16'd4, 4'd0);
      do_sync();
      for (int k = 0; k < 10; k++) wait_sig(0, 1'b1, n);
      check("pre-rst os_tick", int'(os_tick), 1);
      check("pre-rst baud_clk", int'(baud_clk), 0);
      #2 reset = 1'b0;
      #1;
      check("async rst os_tick", int'(os_tick), 0);
      check("async rst baud_tick", int'(baud_tick), 0);
      check("async rst baud_clk", int'(baud_clk), 1);
      check("async rst div_active", int'(div_active), 10);
      #1 reset = 1'b1;
      wait_sig(0, 1'b1, n); check("post-rst first os", n, 10);

      // Fractional divisor D=10, frac=8/16 over 16 oversample periods.
      load_idle(16'd10, 4'd8);
      do_sync();
      tot = 0; p0 = 0; p1 = 0;
      for (int k = 0; k < 16; k++) begin
         wait_sig(0, 1'b1, n);
         if (k == 0) p0 = n;
         if (k == 1) p1 = n;
         tot += n;
      end
`ifdef BAUD_GEN_FRAC_EN
      check("frac period 0", p0, 10);
      check("frac period 1", p1, 11);
      check("frac 16 periods", tot, 168);
`else
      check("nofrac period 0", p0, 10);
      check("nofrac period 1", p1, 10);
      check("nofrac 16 periods", tot, 160);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_DEFAULT, default 9600, meaning the baud rate selected out of reset.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, meaning the oversample ticks per bit; it must be an even value of at least 4.
REQ-004 The block SHALL have parameter DIV_W, default 16, meaning the prescaler divisor width.
REQ-005 The block SHALL have port clk, input, 1 bit: the system clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: tick generation enable.
REQ-008 The block SHALL have port sync, input, 1 bit: single-cycle phase-restart strobe.
REQ-009 The block SHALL have port div_value, input, DIV_W bits: clk cycles per oversample tick.
REQ-010 The block SHALL have port div_frac, input, 4 bits: fractional divisor in sixteenths.
REQ-011 The block SHALL have port div_load, input, 1 bit: single-cycle strobe that captures div_value and div_frac.
REQ-012 The block SHALL have port os_tick, output, 1 bit: one-cycle pulse per oversample period.
REQ-013 The block SHALL have port baud_tick, output, 1 bit: one-cycle pulse per bit period.
REQ-014 The block SHALL have port baud_clk, output, 1 bit: 50% duty square wave at the baud rate.
REQ-015 The block SHALL have port div_active, output, DIV_W bits: the divisor currently in use.

Function
REQ-016 The prescaler SHALL count 0..D-1 while en=1, where D is the active divisor; D=0 SHALL be treated as D=1.
REQ-017 os_tick SHALL be registered and high for exactly one cycle per prescaler wrap.
- First os_tick occurs D cycles after en is first sampled high.
REQ-018 The oversample counter os_cnt SHALL count 0..OVERSAMPLE-1, advancing on each os_tick.
REQ-019 baud_tick SHALL assert in the same cycle as the os_tick that wraps os_cnt from OVERSAMPLE-1 to 0.
REQ-020 baud_clk SHALL be registered, high while os_cnt < OVERSAMPLE/2 and low otherwise.
REQ-021 When en=0, the counters SHALL hold, os_tick and baud_tick SHALL be 0, and baud_clk SHALL hold its value.
REQ-022 On sync=1, the prescaler, os_cnt and the fractional accumulator SHALL clear to 0 and baud_clk SHALL be set to 1.
- No tick in that cycle.
- Next os_tick D cycles later.
REQ-023 A div_load while en=0 SHALL update the active divisor immediately.
REQ-024 A div_load while en=1 SHALL stage the value, and the staged value SHALL become active at the next prescaler wrap.
- The current period is never truncated.
REQ-025 A second div_load before a staged value becomes active SHALL overwrite the staged value.
REQ-026 When sync and div_load occur in the same cycle, the new divisor SHALL become active immediately and the phase restart SHALL use it.
REQ-027 div_active SHALL reflect the active divisor, not the staged one.

Reset
REQ-028 Asserting reset=0 SHALL, asynchronously, clear all counters, clear os_tick and baud_tick to 0, set baud_clk to 1, clear the staging register, and load the active divisor from BAUD_DEFAULT.
- Default divisor = CLK_FREQ_HZ / (BAUD_DEFAULT*OVERSAMPLE), rounded to nearest: 651 at the defaults.
- Default fraction = 0.
REQ-029 Reset asserted mid-period SHALL abandon the period with no partial tick.
- After reset release the first os_tick occurs D cycles after en is sampled high.

Configuration
REQ-030 Macro BAUD_GEN_FRAC_EN SHALL control fractional division as follows.
- Defined: a 4-bit accumulator adds div_frac at each prescaler wrap; on carry-out, the next oversample period is D+1 cycles.
- Not defined: div_frac is ignored, no accumulator is built, and every period is exactly D cycles.

Structure
REQ-031 Package baud_pkg SHALL hold:
- OVERSAMPLE_DEF
- DIV_W_DEF
- FRAC_W=4
- the constant function computing the default divisor from CLK_FREQ_HZ, BAUD_DEFAULT and OVERSAMPLE.
REQ-032 The prescaler (divisor registers, staging, fractional accumulator and os_tick generation) SHALL be a sub-module named baud_prescaler, instantiated once.

Verification
REQ-033 The bench SHALL cover the following directed scenarios.
- CLK_FREQ_HZ=1_536_000, BAUD_DEFAULT=9600, OVERSAMPLE=16, release reset, en=1 -> div_active=10; os_tick every 10 cycles; baud_tick every 160 cycles; baud_clk high 80 / low 80.
- div_load with div_value=4 mid-period while en=1 -> current 10-cycle period completes, then os_tick every 4 cycles; div_active changes at the wrap.
- div_value=0 loaded with en=0, then en=1 -> os_tick every cycle; baud_tick every 16 cycles.
- sync pulsed with os_cnt=7, D=10 -> no tick in the sync cycle; baud_clk=1; os_tick 10 cycles later; baud_tick 160 cycles after sync.
- reset=0 pulsed asynchronously mid-period -> outputs clear immediately; div_active returns to 10.
- With BAUD_GEN_FRAC_EN, D=10, div_frac=8 -> oversample periods alternate 10/11 cycles; 16 periods total 168 cycles.
- Without BAUD_GEN_FRAC_EN, D=10, div_frac=8 -> 16 periods total 160 cycles.
